// File: rtl/norm_shift_stage.sv
// Iterative left-normalization stage for the pipelined FPU adder.
// Shifts the mantissa left one bit per cycle until it is normalized, subnormal or zero.
package norm_shift_pkg;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float_point_num;
endpackage

module norm_shift_stage
    import norm_shift_pkg::*;
#(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MANT_W = 23
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              denorm_i,
    input  float_point_num    answer_i,
    input  logic [MANT_W:0]   mant_i,
    input  logic              sign_i,
    input  logic [EXP_W-1:0]  exp_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output float_point_num    answer_o,
    output logic              underflow_o,
    output logic              zero_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [MANT_W:0]   mant_q, mant_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              sign_q, sign_d;
    float_point_num    answer_q, answer_d;
    logic              underflow_q, underflow_d;
    logic              zero_q, zero_d;

    always_comb begin
        state_d     = state_q;
        mant_d      = mant_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        answer_d    = answer_q;
        underflow_d = underflow_q;
        zero_d      = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    underflow_d = 1'b0;
                    zero_d      = 1'b0;
                    if (!denorm_i) begin
                        answer_d = answer_i;
                        state_d  = DONE;
                    end else begin
                        mant_d  = mant_i;
                        exp_d   = exp_i;
                        sign_d  = sign_i;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                // Priority: zero, normalized, subnormal floor, then shift once more.
                if (mant_q == '0) begin
                    answer_d.sign = sign_q;
                    answer_d.exp  = '0;
                    answer_d.mant = '0;
                    zero_d        = 1'b1;
                    state_d       = DONE;
                end else if (mant_q[MANT_W]) begin
                    answer_d.sign = sign_q;
                    answer_d.exp  = exp_q;
                    answer_d.mant = mant_q[MANT_W-1:0];
                    state_d       = DONE;
                end else if (exp_q <= EXP_W'(1)) begin
                    answer_d.sign = sign_q;
                    answer_d.exp  = '0;
                    answer_d.mant = mant_q[MANT_W-1:0];
                    underflow_d   = 1'b1;
                    state_d       = DONE;
                end else begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - EXP_W'(1);
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mant_q      <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            answer_q    <= '0;
            underflow_q <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mant_q      <= mant_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            answer_q    <= answer_d;
            underflow_q <= underflow_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign answer_o    = answer_q;
    assign underflow_o = underflow_q;
    assign zero_o      = zero_q;

endmodule

// File: tb/tb_norm_shift_stage.sv
// Randomized self-checking bench for norm_shift_stage against an arithmetic reference model.
module tb_norm_shift_stage;
    import norm_shift_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           denorm = 1'b0;
    float_point_num answer_in = '0;
    logic [23:0]    mant = '0;
    logic           sign = 1'b0;
    logic [7:0]     exp_v = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    float_point_num answer_out;
    logic           underflow;
    logic           zero;
    logic [31:0]    ans_bits;

    int errors = 0;
    int checks = 0;

    assign ans_bits = answer_out;

    always #5 clk = ~clk;

    norm_shift_stage #(.EXP_W(8), .MANT_W(23)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .denorm_i    (denorm),
        .answer_i    (answer_in),
        .mant_i      (mant),
        .sign_i      (sign),
        .exp_i       (exp_v),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .answer_o    (answer_out),
        .underflow_o (underflow),
        .zero_o      (zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: value-level normalization with counted shifts, no state machine.
    task automatic model(input logic den, input logic [31:0] ans, input logic [23:0] m,
                         input logic s, input logic [7:0] e,
                         output logic [31:0] r, output logic uf, output logic zf,
                         output int lat);
        int msb;
        int k;
        int sh;
        logic [23:0] mm;
        logic [7:0]  ne;
        uf = 1'b0;
        zf = 1'b0;
        if (!den) begin
            r   = ans;
            lat = 0;
        end else if (m == 24'd0) begin
            r   = {s, 31'd0};
            zf  = 1'b1;
            lat = 1;
        end else begin
            msb = 0;
            for (int i = 0; i < 24; i++) if (m[i]) msb = i;
            k = 23 - msb;
            if (int'(e) > k) begin
                mm  = m << k;
                ne  = 8'(int'(e) - k);
                r   = {s, ne, mm[22:0]};
                lat = k + 1;
            end else begin
                sh  = (e > 8'd1) ? int'(e) - 1 : 0;
                mm  = m << sh;
                r   = {s, 8'd0, mm[22:0]};
                uf  = 1'b1;
                lat = sh + 1;
            end
        end
    endtask

    task automatic run(input string tag, input logic den, input logic [31:0] ans,
                       input logic [23:0] m, input logic s, input logic [7:0] e,
                       input int hold);
        logic [31:0] r;
        logic        uf;
        logic        zf;
        int          lat_exp;
        int          lat;
        int          w;
        model(den, ans, m, s, e, r, uf, zf, lat_exp);
        w = 0;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1; w++;
        end
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        denorm    = den;
        answer_in = ans;
        mant      = m;
        sign      = s;
        exp_v     = e;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        check({tag, "_answer"}, ans_bits, r);
        check({tag, "_flags"}, {30'd0, underflow, zero}, {30'd0, uf, zf});
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, {in_ready, out_valid, underflow, zero, ans_bits[27:0]},
                  {1'b0, 1'b1, uf, zf, r[27:0]});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        logic [23:0] rm;
        #2;
        check("reset_out", {29'd0, out_valid, underflow, zero}, 32'd0);
        check("reset_answer", ans_bits, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run("pass",    1'b0, 32'h40490FDB, 24'h0,      1'b0, 8'h00, 0);
        run("short",   1'b1, 32'h0,        24'h200000, 1'b1, 8'h80, 0);
        run("worst",   1'b1, 32'h0,        24'h000001, 1'b0, 8'h7F, 0);
        run("under",   1'b1, 32'h0,        24'h100000, 1'b0, 8'h02, 0);
        run("zero",    1'b1, 32'h0,        24'h000000, 1'b1, 8'h85, 0);
        run("k0",      1'b1, 32'h0,        24'h800001, 1'b0, 8'h01, 0);
        run("e0",      1'b1, 32'h0,        24'h000100, 1'b1, 8'h00, 0);
        run("stall",   1'b1, 32'h0,        24'h003456, 1'b0, 8'h40, 5);

        for (int n = 0; n < 40; n++) begin
            rm = 24'($urandom) >> $urandom_range(0, 24);
            run("rand", 1'($urandom_range(0, 3) != 0), $urandom, rm, 1'($urandom),
                ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 30)) : 8'($urandom),
                int'($urandom_range(0, 2)));
        end

        // Abort a long normalization mid-shift with asynchronous reset.
        in_valid  = 1'b1;
        denorm    = 1'b1;
        mant      = 24'h000001;
        exp_v     = 8'h7F;
        sign      = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("pre_reset_busy", {30'd0, in_ready, out_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_out", {29'd0, out_valid, underflow, zero}, 32'd0);
        check("abort_answer", ans_bits, 32'd0);
        check("abort_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_output", 32'(seen), 32'd0);
        run("after_reset", 1'b1, 32'h0, 24'h0C0000, 1'b0, 8'h90, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
